// File: rtl/mul_pkg.sv
// ============================================================================
// Module      : mul_pkg
// Description : Shared op/state encodings and width default for ex_mul_unit.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mul_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } mul_state_e;

endpackage

`default_nettype wire

// File: rtl/ex_mul_unit.sv
// ============================================================================
// Module      : ex_mul_unit
// Description : Iterative radix-2 shift-add RV32M multiplier (MUL/MULH/MULHSU/
//               MULHU). Optional MUL_EARLY_TERM_EN stops iterating once the
//               remaining multiplier bits are all zero.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ex_mul_unit
  import mul_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]     c_last    = CW'(XLEN - 1);
  localparam logic [CW-1:0]     c_cnt_one = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   c_one     = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] c_one_w   = {{(2*XLEN-1){1'b0}}, 1'b1};

  mul_state_e        r_state;
  mul_op_e           r_op;
  logic              r_neg;
  logic [4:0]        r_rd;
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [CW-1:0]     r_cnt;
  logic              r_done;
  logic [XLEN-1:0]   r_result;
  logic [4:0]        r_rd_out;

  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [2*XLEN-1:0] w_sum;
  logic [2*XLEN-1:0] w_final;
  logic              w_last;

  // MUL uses signed magnitudes like MULH; the low word is the same either way.
  assign w_a_signed = (op != MUL_OP_MULHU);
  assign w_b_signed = (op == MUL_OP_MUL) || (op == MUL_OP_MULH);
  assign w_a_neg    = w_a_signed & a[XLEN-1];
  assign w_b_neg    = w_b_signed & b[XLEN-1];
  assign w_a_mag    = w_a_neg ? (~a + c_one) : a;
  assign w_b_mag    = w_b_neg ? (~b + c_one) : b;

  assign w_sum   = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_final = r_neg ? (~r_acc + c_one_w) : r_acc;

`ifdef MUL_EARLY_TERM_EN
  // r_mplier holds the multiplier already shifted by the previous iteration.
  assign w_last = (r_cnt == c_last) || (r_mplier == '0);
`else
  assign w_last = (r_cnt == c_last);
`endif

  assign busy   = ((r_state == S_IDLE) && start) ||
                  (r_state == S_CALC) || (r_state == S_SIGN);
  assign done   = r_done;
  assign result = r_result;
  assign rd_out = r_rd_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= MUL_OP_MUL;
      r_neg    <= 1'b0;
      r_rd     <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_rd_out <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_op     <= mul_op_e'(op);
            r_rd     <= rd_in;
            r_neg    <= w_a_neg ^ w_b_neg;
            r_mcand  <= {{XLEN{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc    <= w_sum;
          r_mcand  <= {r_mcand[2*XLEN-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
          r_cnt    <= r_cnt + c_cnt_one;
          if (w_last) r_state <= S_SIGN;
        end
        S_SIGN: begin
          r_result <= (r_op == MUL_OP_MUL) ? w_final[XLEN-1:0]
                                           : w_final[2*XLEN-1:XLEN];
          r_rd_out <= r_rd;
          r_done   <= 1'b1;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_mul_unit.sv
// ============================================================================
// Module      : tb_ex_mul_unit
// Description : Self-checking bench for ex_mul_unit against an arithmetic model;
//               honours MUL_EARLY_TERM_EN for expected latencies.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_ex_mul_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  rd_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int errors = 0;
  int checks = 0;

  ex_mul_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .start(start), .op(op),
    .a(a), .b(b), .rd_in(rd_in), .busy(busy), .done(done),
    .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sa, sb, ub;
    longint unsigned uu;
    logic [63:0] p;
    logic [31:0] lo;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    ub = longint'({32'd0, y});
    case (o)
      2'b00: begin lo = x * y; return lo; end
      2'b01: p = sa * sb;
      2'b10: p = sa * ub;
      default: begin uu = {32'd0, x}; uu = uu * {32'd0, y}; p = uu; end
    endcase
    return p[63:32];
  endfunction

  function automatic int model_latency(input logic [1:0] o, input logic [31:0] y);
    logic [31:0] mag;
    int idx;
    mag = ((o == 2'b00 || o == 2'b01) && y[31]) ? (32'd0 - y) : y;
    idx = -1;
    for (int i = 0; i < 32; i++) if (mag[i]) idx = i;
`ifdef MUL_EARLY_TERM_EN
    if (idx < 0) return 3;
    return (idx + 4 > 34) ? 34 : idx + 4;
`else
    return 34 + (idx - idx);
`endif
  endfunction

  // Issues one op and watches until done; lat = -1 if done never arrives.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] r, input bit hold,
                        output logic [31:0] res, output logic [4:0] rdo,
                        output int lat, output int bcnt);
    lat = -1; bcnt = 0; res = 'x; rdo = 'x;
    @(negedge clk);
    op = o; a = x; b = y; rd_in = r; start = 1'b1;
    #1;
    if (busy) bcnt++;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      #1;
      if (busy) bcnt++;
      if (done) begin lat = k; res = result; rdo = rd_out; break; end
    end
    if (!hold) start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h want=0", result); end
    checks++; if (rd_out !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d want=0", rd_out); end
  endtask

  task automatic test_directed;
    logic [31:0] res; logic [4:0] rdo; int lat, bc;
    logic [1:0]  ops [5] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11};
    logic [31:0] av  [5] = '{32'd7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bv  [5] = '{32'd6, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ev  [5] = '{32'd42, 32'h00000000, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], av[i], bv[i], 5'(i + 5), 1'b0, res, rdo, lat, bc);
      checks++; if (res !== ev[i]) begin errors++; $display("FAIL dir%0d_result got=%h want=%h", i, res, ev[i]); end
      checks++; if (rdo !== 5'(i + 5)) begin errors++; $display("FAIL dir%0d_rd got=%0d want=%0d", i, rdo, i + 5); end
      checks++; if (lat !== model_latency(ops[i], bv[i])) begin errors++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, model_latency(ops[i], bv[i])); end
      if (i == 0) begin
        checks++; if (bc !== model_latency(ops[i], bv[i])) begin errors++; $display("FAIL mul_busy_cycles got=%0d want=%0d", bc, model_latency(ops[i], bv[i])); end
        repeat (3) @(negedge clk);
        #1;
        checks++; if (result !== 32'd42) begin errors++; $display("FAIL result_hold got=%h want=%h", result, 32'd42); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got=%b want=0", done); end
      end
    end
  endtask

  task automatic test_flush;
    logic [31:0] res; logic [4:0] rdo; int lat, bc;
    bit seen;
    @(negedge clk);
    op = 2'b00; a = 32'h12345678; b = 32'hFFFF0009; rd_in = 5'd9; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b want=0", busy); end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (done) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_done got=%b want=0", seen); end
    run_op(2'b00, 32'd3, 32'd3, 5'd4, 1'b0, res, rdo, lat, bc);
    checks++; if (res !== 32'd9) begin errors++; $display("FAIL after_flush_result got=%h want=%h", res, 32'd9); end
    checks++; if (lat !== model_latency(2'b00, 32'd3)) begin errors++; $display("FAIL after_flush_latency got=%0d want=%0d", lat, model_latency(2'b00, 32'd3)); end
  endtask

  task automatic test_reset_mid;
    bit seen;
    @(negedge clk);
    op = 2'b11; a = 32'hDEADBEEF; b = 32'hFFFFFFFF; rd_in = 5'd17; start = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b want=0", busy); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL midreset_result got=%h want=0", result); end
    checks++; if (rd_out !== 5'd0) begin errors++; $display("FAIL midreset_rd got=%0d want=0", rd_out); end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (done) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midreset_no_done got=%b want=0", seen); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] res; logic [4:0] rdo; int lat, bc;
    // start stays high through the first op; the second op is the IDLE cycle after DONE
    run_op(2'b01, 32'h80000000, 32'h00000003, 5'd21, 1'b1, res, rdo, lat, bc);
    checks++; if (res !== model_result(2'b01, 32'h80000000, 32'd3)) begin errors++; $display("FAIL b2b_first_result got=%h want=%h", res, model_result(2'b01, 32'h80000000, 32'd3)); end
    checks++; if (lat !== model_latency(2'b01, 32'd3)) begin errors++; $display("FAIL b2b_first_latency got=%0d want=%0d", lat, model_latency(2'b01, 32'd3)); end
    run_op(2'b10, 32'hFFFFFFF0, 32'h80000001, 5'd22, 1'b0, res, rdo, lat, bc);
    checks++; if (res !== model_result(2'b10, 32'hFFFFFFF0, 32'h80000001)) begin errors++; $display("FAIL b2b_second_result got=%h want=%h", res, model_result(2'b10, 32'hFFFFFFF0, 32'h80000001)); end
    checks++; if (rdo !== 5'd22) begin errors++; $display("FAIL b2b_second_rd got=%0d want=22", rdo); end
  endtask

  task automatic test_early_term;
    logic [31:0] res; logic [4:0] rdo; int lat, bc;
    int want53, want50;
`ifdef MUL_EARLY_TERM_EN
    want53 = 5; want50 = 3;
`else
    want53 = 34; want50 = 34;
`endif
    run_op(2'b00, 32'd5, 32'd3, 5'd1, 1'b0, res, rdo, lat, bc);
    checks++; if (res !== 32'd15) begin errors++; $display("FAIL et_5x3_result got=%h want=%h", res, 32'd15); end
    checks++; if (lat !== want53) begin errors++; $display("FAIL et_5x3_latency got=%0d want=%0d", lat, want53); end
    run_op(2'b00, 32'd5, 32'd0, 5'd2, 1'b0, res, rdo, lat, bc);
    checks++; if (res !== 32'd0) begin errors++; $display("FAIL et_5x0_result got=%h want=0", res); end
    checks++; if (lat !== want50) begin errors++; $display("FAIL et_5x0_latency got=%0d want=%0d", lat, want50); end
  endtask

  task automatic test_random;
    logic [31:0] res, x, y; logic [4:0] rdo, r; logic [1:0] o; int lat, bc;
    logic [31:0] corner [4] = '{32'h0, 32'h80000000, 32'hFFFFFFFF, 32'h1};
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : ($urandom >> $urandom_range(0, 31));
      r = 5'($urandom_range(0, 31));
      run_op(o, x, y, r, 1'b0, res, rdo, lat, bc);
      checks++; if (res !== model_result(o, x, y)) begin errors++; $display("FAIL rand%0d_result op=%0d a=%h b=%h got=%h want=%h", i, o, x, y, res, model_result(o, x, y)); end
      checks++; if (rdo !== r) begin errors++; $display("FAIL rand%0d_rd got=%0d want=%0d", i, rdo, r); end
      checks++; if (lat !== model_latency(o, y)) begin errors++; $display("FAIL rand%0d_latency b=%h got=%0d want=%0d", i, y, lat, model_latency(o, y)); end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_flush;
    test_reset_mid;
    test_back_to_back;
    test_early_term;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
